// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation and commit, out-of-order
// writeback by tag, with operand lookup for the reservation stations.
module reorder_buffer #(
  parameter int ROB_SIZE = 4,
  parameter int REG_SIZE = 64,
  parameter int GPR_IDX_SIZE = 5,
  localparam int TAG_W = $clog2(ROB_SIZE)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_alloc_valid,
  input  logic [GPR_IDX_SIZE-1:0] i_alloc_gpr_index,
  output logic                    o_alloc_ready,
  output logic [TAG_W-1:0]        o_alloc_tag,
  input  logic                    i_wb_valid,
  input  logic [TAG_W-1:0]        i_wb_tag,
  input  logic [REG_SIZE-1:0]     i_wb_value,
  input  logic [TAG_W-1:0]        i_query_tag,
  output logic                    o_query_done,
  output logic [REG_SIZE-1:0]     o_query_value,
  input  logic                    i_flush,
  output logic                    o_commit,
  output logic [GPR_IDX_SIZE-1:0] o_commit_gpr_index,
  output logic [REG_SIZE-1:0]     o_commit_value,
  output logic [TAG_W-1:0]        o_commit_tag,
  output logic [TAG_W:0]          o_count
);

  localparam int CNT_W = TAG_W + 1;

  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic [GPR_IDX_SIZE-1:0] gpr;
    logic [REG_SIZE-1:0]     value;
  } entry_t;

  entry_t           rob [ROB_SIZE];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic alloc_fire;
  logic wb_fire;
  logic wb_hit;

  // Readiness looks only at registered count; a same-cycle commit
  // does not free a slot until the following cycle.
  assign o_alloc_ready = count < CNT_W'(ROB_SIZE);
  assign o_alloc_tag   = tail;
  assign o_count       = count;

  assign alloc_fire = i_alloc_valid && o_alloc_ready && !i_flush;
  assign wb_fire    = i_wb_valid && rob[i_wb_tag].valid && !i_flush;

  assign o_commit = rob[head].valid && rob[head].done && !i_flush;
  assign o_commit_gpr_index = o_commit ? rob[head].gpr : '0;
  assign o_commit_value     = o_commit ? rob[head].value : '0;
  assign o_commit_tag       = o_commit ? head : '0;

  assign wb_hit = i_wb_valid && (i_wb_tag == i_query_tag);

  always_comb begin
    o_query_done  = 1'b0;
    o_query_value = '0;
    if (rob[i_query_tag].valid && (rob[i_query_tag].done || wb_hit)) begin
      o_query_done  = 1'b1;
      o_query_value = wb_hit ? i_wb_value : rob[i_query_tag].value;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob[i] <= '0;
      end
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].done  <= 1'b0;
      end
    end else begin
      if (wb_fire) begin
        rob[i_wb_tag].done  <= 1'b1;
        rob[i_wb_tag].value <= i_wb_value;
      end
      // Commit clears after writeback so a late rewrite of head cannot revive it
      if (o_commit) begin
        rob[head].valid <= 1'b0;
        rob[head].done  <= 1'b0;
        head <= head + TAG_W'(1);
      end
      if (alloc_fire) begin
        rob[tail].valid <= 1'b1;
        rob[tail].done  <= 1'b0;
        rob[tail].gpr   <= i_alloc_gpr_index;
        tail <= tail + TAG_W'(1);
      end
      count <= count + CNT_W'(alloc_fire) - CNT_W'(o_commit);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard.
// Expected commits are queued when writeback is driven.
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n;
  logic        alloc_valid;
  logic [4:0]  alloc_gpr;
  logic        alloc_ready;
  logic [1:0]  alloc_tag;
  logic        wb_valid;
  logic [1:0]  wb_tag;
  logic [63:0] wb_value;
  logic [1:0]  query_tag;
  logic        query_done;
  logic [63:0] query_value;
  logic        flush;
  logic        commit;
  logic [4:0]  commit_gpr;
  logic [63:0] commit_value;
  logic [1:0]  commit_tag;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  gpr;
    logic [63:0] val;
    logic [1:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  reorder_buffer #(
    .ROB_SIZE(4),
    .REG_SIZE(64),
    .GPR_IDX_SIZE(5)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_alloc_valid(alloc_valid),
    .i_alloc_gpr_index(alloc_gpr),
    .o_alloc_ready(alloc_ready),
    .o_alloc_tag(alloc_tag),
    .i_wb_valid(wb_valid),
    .i_wb_tag(wb_tag),
    .i_wb_value(wb_value),
    .i_query_tag(query_tag),
    .o_query_done(query_done),
    .o_query_value(query_value),
    .i_flush(flush),
    .o_commit(commit),
    .o_commit_gpr_index(commit_gpr),
    .o_commit_value(commit_value),
    .o_commit_tag(commit_tag),
    .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] g, input logic [63:0] v,
                      input logic [1:0] t);
    exp_t e;
    e.gpr = g;
    e.val = v;
    e.tag = t;
    sb.push_back(e);
  endtask

  // Scoreboard compare at negedge, then advance one edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (commit === 1'b1) begin
      if (sb.size() == 0) begin
        chk("commit_unexpected", 64'(commit), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("commit_gpr", 64'(commit_gpr), 64'(e.gpr));
        chk("commit_value", commit_value, e.val);
        chk("commit_tag", 64'(commit_tag), 64'(e.tag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_valid = 1'b0;
    alloc_gpr = '0;
    wb_valid = 1'b0;
    wb_tag = '0;
    wb_value = '0;
    query_tag = '0;
    flush = 1'b0;
    #12;
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_commit", 64'(commit), 64'd0);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_qdone", 64'(query_done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: fill
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_gpr = 5'(i + 1);
      chk("fill_ready", 64'(alloc_ready), 64'd1);
      chk("fill_tag", 64'(alloc_tag), 64'(i));
      tick();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    alloc_gpr = 5'd9;
    tick();
    alloc_valid = 1'b0;
    chk("ignored_count", 64'(count), 64'd4);
    chk("ignored_tail", 64'(alloc_tag), 64'd0);

    // 2: out-of-order writeback, in-order commit
    wb_valid = 1'b1;
    wb_tag = 2'd2;
    wb_value = 64'h30;
    tick();
    chk("wait_head", 64'(commit), 64'd0);
    wb_tag = 2'd0;
    wb_value = 64'h10;
    push(5'd1, 64'h10, 2'd0);
    tick();
    wb_valid = 1'b0;
    chk("commit0_hi", 64'(commit), 64'd1);
    tick();
    chk("commit0_lo", 64'(commit), 64'd0);
    chk("count3", 64'(count), 64'd3);
    wb_valid = 1'b1;
    wb_tag = 2'd1;
    wb_value = 64'h20;
    push(5'd2, 64'h20, 2'd1);
    push(5'd3, 64'h30, 2'd2);
    tick();
    wb_valid = 1'b0;
    chk("commit1_hi", 64'(commit), 64'd1);
    tick();
    chk("commit2_hi", 64'(commit), 64'd1);
    tick();
    chk("tag3_waits", 64'(commit), 64'd0);
    chk("count1", 64'(count), 64'd1);
    chk("sb_empty2", 64'(sb.size()), 64'd0);

    // 3: full with head done, alloc held -> freed slot, tail wraps
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_gpr = 5'(i + 5);
      tick();
    end
    alloc_gpr = 5'd9;
    wb_valid = 1'b1;
    wb_tag = 2'd0;
    wb_value = 64'h55;
    push(5'd5, 64'h55, 2'd0);
    tick();
    wb_valid = 1'b0;
    chk("full_commit", 64'(commit), 64'd1);
    chk("full_not_ready", 64'(alloc_ready), 64'd0);
    tick();
    chk("freed_ready", 64'(alloc_ready), 64'd1);
    chk("wrap_tag", 64'(alloc_tag), 64'd0);
    tick();
    alloc_valid = 1'b0;
    chk("refill_count", 64'(count), 64'd4);

    // 4: query with same-cycle writeback bypass
    query_tag = 2'd1;
    wb_valid = 1'b1;
    wb_tag = 2'd1;
    wb_value = 64'hAB;
    #1;
    chk("q_bypass_done", 64'(query_done), 64'd1);
    chk("q_bypass_value", query_value, 64'hAB);
    query_tag = 2'd2;
    #1;
    chk("q_pending_done", 64'(query_done), 64'd0);
    chk("q_pending_value", query_value, 64'd0);
    query_tag = 2'd1;
    push(5'd6, 64'hAB, 2'd1);
    tick();
    wb_valid = 1'b0;
    chk("q_stored_done", 64'(query_done), 64'd1);
    chk("q_stored_value", query_value, 64'hAB);
    chk("commit_tag1", 64'(commit), 64'd1);
    tick();
    chk("q_free_done", 64'(query_done), 64'd0);
    chk("q_free_value", query_value, 64'd0);

    // 5: flush with head done
    wb_valid = 1'b1;
    wb_tag = 2'd2;
    wb_value = 64'h22;
    tick();
    wb_valid = 1'b0;
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    #1;
    chk("flush_no_commit", 64'(commit), 64'd0);
    chk("flush_commit_val", commit_value, 64'd0);
    tick();
    flush = 1'b0;
    chk("post_flush_count", 64'(count), 64'd0);
    chk("post_flush_tag", 64'(alloc_tag), 64'd0);
    alloc_valid = 1'b1;
    alloc_gpr = 5'd10;
    tick();
    alloc_valid = 1'b0;
    wb_valid = 1'b1;
    wb_tag = 2'd1;
    wb_value = 64'h99;
    tick();
    wb_valid = 1'b0;
    query_tag = 2'd1;
    #1;
    chk("stale_wb_qdone", 64'(query_done), 64'd0);
    chk("stale_wb_count", 64'(count), 64'd1);
    chk("stale_wb_commit", 64'(commit), 64'd0);
    wb_valid = 1'b1;
    wb_tag = 2'd0;
    wb_value = 64'h44;
    push(5'd10, 64'h44, 2'd0);
    tick();
    wb_valid = 1'b0;
    chk("post_flush_commit", 64'(commit), 64'd1);
    tick();
    chk("post_flush_empty", 64'(count), 64'd0);

    // 6: async reset mid-cycle
    alloc_valid = 1'b1;
    alloc_gpr = 5'd11;
    tick();
    alloc_gpr = 5'd12;
    tick();
    alloc_valid = 1'b0;
    wb_valid = 1'b1;
    wb_tag = 2'd1;
    wb_value = 64'h66;
    tick();
    wb_valid = 1'b0;
    chk("pre_rst_commit", 64'(commit), 64'd1);
    chk("pre_rst_count", 64'(count), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_commit", 64'(commit), 64'd0);
    chk("arst_commit_val", commit_value, 64'd0);
    chk("arst_commit_gpr", 64'(commit_gpr), 64'd0);
    chk("arst_ready", 64'(alloc_ready), 64'd1);
    chk("arst_tag", 64'(alloc_tag), 64'd0);
    rst_n = 1'b1;
    tick();
    alloc_valid = 1'b1;
    alloc_gpr = 5'd13;
    chk("post_rst_tag", 64'(alloc_tag), 64'd0);
    tick();
    alloc_valid = 1'b0;
    chk("post_rst_count", 64'(count), 64'd1);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
